seq_divider: RTL and testbench

- Multi-cycle radix-2 restoring integer divider; produces quotient and remainder for unsigned or signed operands.
- Sits beside the combinational ALU as the inverse of its multiplier.
- The execute stage starts an operation with a start/busy/done handshake and stalls until done.

---
 rtl/seq_divider.sv | 186 ++++++++++++++++++
 tb/tb_seq_divider.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider producing quotient and remainder for
// unsigned or two's-complement operands, one quotient bit per clock.

`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module seq_divider #(
    parameter int n = `DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sign,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quot,
    output logic [n-1:0] rem,
    output logic         div_zero,
    output logic         overflow
);

    localparam int           CW      = $clog2(n + 1);
    localparam logic [n-1:0] MIN_VAL = {1'b1, {(n-1){1'b0}}};
    localparam logic [n-1:0] ONE     = {{(n-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    state_e        state_q, state_d;
    // Dividend shifts out at the msb while quotient bits shift in at the lsb.
    logic [n-1:0]  dvd_q, dvd_d;
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n-1:0]  prem_q, prem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_quot_q, neg_quot_d;
    logic          neg_rem_q, neg_rem_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;
    logic          done_q, done_d;
    logic [n-1:0]  quot_q, quot_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          div_zero_q, div_zero_d;
    logic          overflow_q, overflow_d;

    logic [n-1:0]  abs_a, abs_b;
    logic          is_zero, is_ovf;
    logic [n:0]    trial;

    function automatic logic [n-1:0] negate(input logic [n-1:0] x);
        return ~x + ONE;
    endfunction

    // MIN negates to itself, which is its correct unsigned magnitude.
    assign abs_a   = (sign && a[n-1]) ? negate(a) : a;
    assign abs_b   = (sign && b[n-1]) ? negate(b) : b;
    assign is_zero = (b == '0);
    assign is_ovf  = sign && (a == MIN_VAL) && (b == '1);

    // The partial remainder is below 2^(n-1) before every shift, so its msb is never lost.
    assign trial = {1'b0, prem_q[n-2:0], dvd_q[n-1]} - {1'b0, dvs_q};

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    dz_d       = is_zero;
                    ov_d       = is_ovf;
                    if (is_zero) begin
                        dvd_d      = '1;
                        prem_d     = a;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = FIX;
                    end else if (is_ovf) begin
                        dvd_d      = MIN_VAL;
                        prem_d     = '0;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = FIX;
                    end else begin
                        dvd_d      = abs_a;
                        dvs_d      = abs_b;
                        prem_d     = '0;
                        neg_quot_d = sign && (a[n-1] ^ b[n-1]);
                        neg_rem_d  = sign && a[n-1];
                        cnt_d      = CW'(n);
                        state_d    = RUN;
                    end
                end
            end

            RUN: begin
                if (!trial[n]) begin
                    prem_d = trial[n-1:0];
                    dvd_d  = {dvd_q[n-2:0], 1'b1};
                end else begin
                    prem_d = {prem_q[n-2:0], dvd_q[n-1]};
                    dvd_d  = {dvd_q[n-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quot_d     = neg_quot_q ? negate(dvd_q) : dvd_q;
                rem_d      = neg_rem_q  ? negate(prem_q) : prem_q;
                div_zero_d = dz_q;
                overflow_d = ov_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: every register, datapath included, is cleared so an aborted operation leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all registers see pre-edge values.
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            ov_q       <= ov_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at n=8: latency, signed/unsigned results,
// divide-by-zero, signed overflow, handshake corner cases and reset abort.

module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_zero;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    seq_divider #(.n(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Start pulse covers one rising edge (edge 0); returns at the following negedge.
    // Operands are scrambled afterwards to show the latched copies are used.
    task automatic do_start(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        sign  = s;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = av ^ 8'hA5;
        b     = 8'h00;
    endtask

    // lat = edge index (edge 0 = start edge) after which done is seen, -1 on timeout.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int bc);
        do_start(s, av, bv);
        wait_done(lat, bc);
    endtask

    task automatic test_reset();
        tests++;
        if ({busy, done, div_zero, overflow} !== 4'b0000) begin
            $display("FAIL reset_flags: busy/done/dz/ov got %b%b%b%b want 0000", busy, done, div_zero, overflow);
            fails++;
        end
        tests++;
        if (quot !== 8'h00 || rem !== 8'h00) begin
            $display("FAIL reset_results: quot=%h rem=%h want 00 00", quot, rem);
            fails++;
        end
    endtask

    task automatic test_unsigned();
        int lat, bc;
        logic [W-1:0] va [4] = '{8'd255, 8'hFF, 8'd7,  8'd200};
        logic [W-1:0] vb [4] = '{8'd16,  8'h81, 8'd100, 8'd1};
        logic [W-1:0] eq [4] = '{8'd15,  8'd1,  8'd0,  8'd200};
        logic [W-1:0] er [4] = '{8'd15,  8'h7E, 8'd7,  8'd0};
        run_op(1'b0, 8'd100, 8'd7, lat, bc);
        tests++;
        if (lat !== 9 || bc !== 9) begin
            $display("FAIL u_latency: done edge %0d busy cycles %0d want 9 9", lat, bc);
            fails++;
        end
        tests++;
        if (quot !== 8'd14 || rem !== 8'd2 || div_zero !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL u_100_7: quot=%0d rem=%0d dz=%b ov=%b want 14 2 0 0", quot, rem, div_zero, overflow);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || quot !== 8'd14 || rem !== 8'd2) begin
            $display("FAIL u_hold: done=%b busy=%b quot=%0d rem=%0d want 0 0 14 2", done, busy, quot, rem);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, va[i], vb[i], lat, bc);
            tests++;
            if (lat !== 9 || quot !== eq[i] || rem !== er[i]) begin
                $display("FAIL u_vec%0d: %h/%h lat=%0d quot=%h rem=%h want 9 %h %h",
                         i, va[i], vb[i], lat, quot, rem, eq[i], er[i]);
                fails++;
            end
        end
    endtask

    task automatic test_signed();
        int lat, bc;
        logic [W-1:0] va [6] = '{8'hF9, 8'h80, 8'h07, 8'hF9, 8'h80, 8'h64};
        logic [W-1:0] vb [6] = '{8'h02, 8'h02, 8'hFE, 8'hFE, 8'hFE, 8'h07};
        logic [W-1:0] eq [6] = '{8'hFD, 8'hC0, 8'hFD, 8'h03, 8'h40, 8'h0E};
        logic [W-1:0] er [6] = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h02};
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, va[i], vb[i], lat, bc);
            tests++;
            if (lat !== 9 || quot !== eq[i] || rem !== er[i] || overflow !== 1'b0 || div_zero !== 1'b0) begin
                $display("FAIL s_vec%0d: %h/%h lat=%0d quot=%h rem=%h ov=%b dz=%b want 9 %h %h 0 0",
                         i, va[i], vb[i], lat, quot, rem, overflow, div_zero, eq[i], er[i]);
                fails++;
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], 8'h55, 8'h00, lat, bc);
            tests++;
            if (lat !== 1 || quot !== 8'hFF || rem !== 8'h55 || div_zero !== 1'b1 || overflow !== 1'b0) begin
                $display("FAIL dz_sign%0d: lat=%0d quot=%h rem=%h dz=%b ov=%b want 1 ff 55 1 0",
                         s, lat, quot, rem, div_zero, overflow);
                fails++;
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || div_zero !== 1'b1 || quot !== 8'hFF) begin
            $display("FAIL dz_hold: done=%b dz=%b quot=%h want 0 1 ff", done, div_zero, quot);
            fails++;
        end
        do_start(1'b0, 8'd100, 8'd7);
        tests++;
        if (busy !== 1'b1 || div_zero !== 1'b0) begin
            $display("FAIL dz_clear: busy=%b dz=%b want 1 0", busy, div_zero);
            fails++;
        end
        wait_done(lat, bc);
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(1'b1, 8'h80, 8'hFF, lat, bc);
        tests++;
        if (lat !== 1 || quot !== 8'h80 || rem !== 8'h00 || overflow !== 1'b1 || div_zero !== 1'b0) begin
            $display("FAIL ovf_signed: lat=%0d quot=%h rem=%h ov=%b dz=%b want 1 80 00 1 0",
                     lat, quot, rem, overflow, div_zero);
            fails++;
        end
        run_op(1'b0, 8'h80, 8'hFF, lat, bc);
        tests++;
        if (lat !== 9 || quot !== 8'h00 || rem !== 8'h80 || overflow !== 1'b0) begin
            $display("FAIL ovf_unsigned: lat=%0d quot=%h rem=%h ov=%b want 9 00 80 0", lat, quot, rem, overflow);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_start(1'b0, 8'd100, 8'd7);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'd50;
        b     = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        tests++;
        if (lat !== 6 || quot !== 8'd14 || rem !== 8'd2) begin
            $display("FAIL b2b_ignore: lat=%0d quot=%0d rem=%0d want 6 14 2", lat, quot, rem);
            fails++;
        end
        start = 1'b1;
        sign  = 1'b0;
        a     = 8'd200;
        b     = 8'd9;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL b2b_accept: done=%b busy=%b want 0 1", done, busy);
            fails++;
        end
        wait_done(lat, bc);
        tests++;
        if (lat !== 9 || quot !== 8'd22 || rem !== 8'd2) begin
            $display("FAIL b2b_result: lat=%0d quot=%0d rem=%0d want 9 22 2", lat, quot, rem);
            fails++;
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, dcnt;
        do_start(1'b0, 8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, div_zero, overflow} !== 4'b0000 || quot !== 8'h00 || rem !== 8'h00) begin
            $display("FAIL abort_clear: busy=%b done=%b dz=%b ov=%b quot=%h rem=%h want all 0",
                     busy, done, div_zero, overflow, quot, rem);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        tests++;
        if (dcnt !== 0) begin
            $display("FAIL abort_quiet: %0d cycles with done/busy after reset want 0", dcnt);
            fails++;
        end
        run_op(1'b0, 8'd100, 8'd7, lat, bc);
        tests++;
        if (lat !== 9 || quot !== 8'd14 || rem !== 8'd2) begin
            $display("FAIL abort_restart: lat=%0d quot=%0d rem=%0d want 9 14 2", lat, quot, rem);
            fails++;
        end
    endtask

    task automatic test_sweep();
        int lat, bc;
        logic [W-1:0] av, bv, eq, er;
        logic signed [W-1:0] sa, sb;
        for (int i = 0; i < 600; i++) begin
            av = W'($urandom);
            bv = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
            if (bv == 8'h00) bv = 8'h01;
            if (i[0] && av == 8'h80 && bv == 8'hFF) bv = 8'hFE;
            if (i[0]) begin
                sa = av;
                sb = bv;
                eq = sa / sb;
                er = sa % sb;
            end else begin
                eq = av / bv;
                er = av % bv;
            end
            run_op(i[0], av, bv, lat, bc);
            tests++;
            if (lat !== 9 || quot !== eq || rem !== er) begin
                $display("FAIL sweep%0d: sign=%b %h/%h lat=%0d quot=%h rem=%h want 9 %h %h",
                         i, i[0], av, bv, lat, quot, rem, eq, er);
                fails++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_sweep();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
